move_engine: RTL

MOVE_ENGINE -- requirements
Module: move_engine

---
 rtl/game_pkg.sv | 42 ++++
 rtl/lane_merge.sv | 65 ++++++
 rtl/move_engine.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the 2048 move engine
// Purpose: tile/board types, direction and FSM enums, tile and LFSR constants,
//          and the lane-to-cell mapping used to walk the board per direction.
// Ports:   none (package).
package game_pkg;

  typedef logic [11:0] tile_t;
  typedef tile_t [0:3][0:3] board_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LANE  = 2'd1,
    ST_SPAWN = 2'd2,
    ST_DONE  = 2'd3
  } move_state_e;

  localparam tile_t       MAX_TILE  = 12'd2048;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Cell {row,col} holding element k of a lane; element 0 is the edge that
  // tiles slide toward. For 2-bit values, 3-k equals ~k.
  function automatic logic [3:0] cell_idx(dir_e d, logic [1:0] lane, logic [1:0] k);
    logic [3:0] idx;
    case (d)
      DIR_UP:    idx = {k, lane};
      DIR_DOWN:  idx = {~k, lane};
      DIR_LEFT:  idx = {lane, k};
      default:   idx = {lane, ~k};
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/lane_merge.sv
// rtl/lane_merge.sv - combinational compact-and-merge of one 4-tile lane
// Purpose: slide non-zero tiles toward element 0, then merge equal adjacent
//          pairs from element 0 upward, each tile merging at most once.
//          2048 tiles never merge, so results stay within 12 bits.
// Ports:   lane_in      4 tiles, element 0 first
//          lane_out     4 tiles after the move
//          lane_changed lane_out differs from lane_in
//          score_delta  sum of merged tile values for this lane
module lane_merge
  import game_pkg::*;
(
  input  logic [0:3][11:0] lane_in,
  output logic [0:3][11:0] lane_out,
  output logic             lane_changed,
  output logic [12:0]      score_delta
);

  logic [0:3][11:0] comp;
  logic [3:0]       can_merge;
  logic [2:0]       n;
  logic [2:0]       k;
  logic             skip;
  tile_t            dbl;

  always_comb begin
    comp = '0;
    n    = '0;
    for (int i = 0; i < 4; i++) begin
      if (lane_in[i] != 12'd0) begin
        comp[n[1:0]] = lane_in[i];
        n            = n + 3'd1;
      end
    end

    can_merge    = '0;
    can_merge[0] = (comp[0] != 12'd0) && (comp[0] == comp[1]) && (comp[0] != MAX_TILE);
    can_merge[1] = (comp[1] != 12'd0) && (comp[1] == comp[2]) && (comp[1] != MAX_TILE);
    can_merge[2] = (comp[2] != 12'd0) && (comp[2] == comp[3]) && (comp[2] != MAX_TILE);

    lane_out    = '0;
    score_delta = '0;
    k           = '0;
    skip        = 1'b0;
    dbl         = '0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        // Second tile of a pair already folded into the previous output.
        skip = 1'b0;
      end else if (comp[i] != 12'd0) begin
        if (can_merge[i]) begin
          dbl         = {comp[i][10:0], 1'b0};
          lane_out[k[1:0]] = dbl;
          score_delta = score_delta + {1'b0, dbl};
          skip        = 1'b1;
        end else begin
          lane_out[k[1:0]] = comp[i];
        end
        k = k + 3'd1;
      end
    end

    lane_changed = (lane_out != lane_in);
  end

endmodule

// File: rtl/move_engine.sv
// rtl/move_engine.sv - 2048 board move engine with spawn and game-over detect
// Purpose: applies one move four lanes at a time through a shared lane_merge,
//          spawns a tile after a changing move, reports completion and status.
// Ports:   clk, rst (sync active-high)
//          new_game                 clear board/score and spawn two tiles
//          move_valid, move_dir     move request, taken only when move_ready
//          move_ready               high in IDLE
//          board_out, score         registered board and saturating score
//          done, moved              completion pulse and board-changed flag
//          game_over                board full with no equal neighbours
module move_engine
  import game_pkg::*;
#(
  parameter logic [15:0] SEED    = LFSR_SEED,
  parameter int          SCORE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    new_game,
  input  logic                    move_valid,
  input  logic [1:0]              move_dir,
  output logic                    move_ready,
  output logic [0:3][0:3][11:0]   board_out,
  output logic [SCORE_W-1:0]      score,
  output logic                    done,
  output logic                    moved,
  output logic                    game_over
);

  move_state_e        state;
  board_t             board;
  logic [SCORE_W-1:0] score_q;
  dir_e               dir_q;
  logic [1:0]         lane;
  logic               spawn_en;
  logic               spawn_cnt;
  logic               moved_acc;
  logic [15:0]        lfsr;

  // Lane gather for the current lane counter and latched direction.
  logic [0:3][3:0]  lane_idx;
  logic [0:3][11:0] lane_in;
  logic [0:3][11:0] lane_out;
  logic             lane_changed;
  logic [12:0]      score_delta;

  always_comb begin
    lane_idx = '0;
    lane_in  = '0;
    for (int k = 0; k < 4; k++) begin
      lane_idx[k] = cell_idx(dir_q, lane, 2'(k));
      lane_in[k]  = board[lane_idx[k][3:2]][lane_idx[k][1:0]];
    end
  end

  lane_merge u_lane_merge (
    .lane_in      (lane_in),
    .lane_out     (lane_out),
    .lane_changed (lane_changed),
    .score_delta  (score_delta)
  );

  // One extra bit catches overflow for saturation; SCORE_W must be >= 13.
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;

  always_comb begin
    score_sum  = {1'b0, score_q} + (SCORE_W+1)'(score_delta);
    score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  // First empty cell at or after lfsr[3:0], wrapping 15 -> 0. Scanning offsets
  // downward lets the smallest offset win.
  logic       spawn_hit;
  logic [3:0] spawn_idx;
  logic [3:0] probe;
  tile_t      spawn_val;

  always_comb begin
    spawn_hit = 1'b0;
    spawn_idx = lfsr[3:0];
    probe     = '0;
    for (int i = 15; i >= 0; i--) begin
      probe = lfsr[3:0] + 4'(i);
      if (board[probe[3:2]][probe[1:0]] == 12'd0) begin
        spawn_hit = 1'b1;
        spawn_idx = probe;
      end
    end
    spawn_val = (lfsr[6:4] == 3'b000) ? 12'd4 : 12'd2;
  end

  // Game-over terms from the settled board.
  logic full;
  logic pair;

  always_comb begin
    full = 1'b1;
    pair = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (board[r][c] == 12'd0) full = 1'b0;
      end
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (board[r][c] == board[r][c+1]) pair = 1'b1;
      end
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (board[r][c] == board[r+1][c]) pair = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    done <= 1'b0;
    if (rst) begin
      state     <= ST_IDLE;
      board     <= '0;
      score_q   <= '0;
      dir_q     <= DIR_UP;
      lane      <= '0;
      spawn_en  <= 1'b0;
      spawn_cnt <= 1'b0;
      moved_acc <= 1'b0;
      moved     <= 1'b0;
      game_over <= 1'b0;
      done      <= 1'b0;
      lfsr      <= SEED;
    end else begin
      case (state)
        ST_IDLE: begin
          if (new_game) begin
            board     <= '0;
            score_q   <= '0;
            spawn_en  <= 1'b1;
            spawn_cnt <= 1'b1;
            moved_acc <= 1'b1;
            state     <= ST_SPAWN;
          end else if (move_valid && !game_over) begin
            dir_q     <= dir_e'(move_dir);
            moved_acc <= 1'b0;
            lane      <= '0;
            state     <= ST_LANE;
          end
        end
        ST_LANE: begin
          for (int k = 0; k < 4; k++) begin
            board[lane_idx[k][3:2]][lane_idx[k][1:0]] <= lane_out[k];
          end
          score_q   <= score_next;
          moved_acc <= moved_acc | lane_changed;
          lane      <= lane + 2'd1;
          if (lane == 2'd3) begin
            spawn_en  <= moved_acc | lane_changed;
            spawn_cnt <= 1'b0;
            state     <= ST_SPAWN;
          end
        end
        ST_SPAWN: begin
          // One cycle is spent here even with nothing to spawn, keeping the
          // move latency fixed.
          if (spawn_en && spawn_hit) begin
            board[spawn_idx[3:2]][spawn_idx[1:0]] <= spawn_val;
          end
          if (spawn_cnt) begin
            spawn_cnt <= 1'b0;
          end else begin
            state <= ST_DONE;
          end
        end
        default: begin
          done      <= 1'b1;
          moved     <= moved_acc;
          game_over <= full && !pair;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign move_ready = (state == ST_IDLE);
  assign board_out  = board;
  assign score      = score_q;

endmodule
